// File: rtl/scan_chain_ctrl.sv
// scan_chain_ctrl: WIDTH-bit scan chain with an internal capture/shift/update sequencer.
// Optional feature macro: SCAN_PARITY_EN adds an even-parity cell at the chain tail.
// With the macro defined, a failing parity check blocks the update and raises PARITY_ERR.
module scan_chain_ctrl #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [1:0]       MODE,
  input  logic             SCAN_IN,
  input  logic [WIDTH-1:0] SCAN_CAPTURE_IN,
  output logic             SCAN_OUT,
  output logic [WIDTH-1:0] SCAN_OUT_UPDT,
  output logic             SHIFT_EN,
  output logic             BUSY,
  output logic             DONE,
  output logic             PARITY_ERR
);

`ifdef SCAN_PARITY_EN
  localparam int unsigned L = WIDTH + 1;
`else
  localparam int unsigned L = WIDTH;
`endif
  // One spare code above L-1 so the terminal-count compare never wraps.
  localparam int unsigned CW = $clog2(WIDTH + 2);

  typedef enum logic [2:0] {StIdle, StCapture, StShift, StUpdate, StFin} state_e;

  state_e           state_q, state_d;
  logic [L-1:0]     shift_q;
  logic [CW-1:0]    cnt_q;
  logic             upd_sel_q;
  logic [WIDTH-1:0] updt_q;
  logic             last_shift;
  logic [L-1:0]     capture_val;
`ifdef SCAN_PARITY_EN
  logic             perr_q;
`endif

  assign last_shift = (cnt_q == CW'(L - 1));

`ifdef SCAN_PARITY_EN
  assign capture_val = {^SCAN_CAPTURE_IN, SCAN_CAPTURE_IN};
`else
  assign capture_val = SCAN_CAPTURE_IN;
`endif

  // State register with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RESET) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Next-state decode; START is only honoured in idle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:    if (START) state_d = MODE[0] ? StCapture : StShift;
      StCapture: state_d = StShift;
      StShift:   if (last_shift) state_d = upd_sel_q ? StUpdate : StFin;
      StUpdate:  state_d = StFin;
      StFin:     state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Datapath: chain, bit counter, mode latch, update register and parity flag.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      shift_q   <= '0;
      cnt_q     <= '0;
      upd_sel_q <= 1'b0;
      updt_q    <= '0;
`ifdef SCAN_PARITY_EN
      perr_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (START) begin
            // Only the update selection is needed after acceptance.
            upd_sel_q <= MODE[1];
`ifdef SCAN_PARITY_EN
            perr_q    <= 1'b0;
`endif
          end
        end
        StCapture: shift_q <= capture_val;
        StShift: begin
          shift_q <= {SCAN_IN, shift_q[L-1:1]};
          cnt_q   <= last_shift ? '0 : cnt_q + CW'(1);
        end
        StUpdate: begin
`ifdef SCAN_PARITY_EN
          if (^shift_q) perr_q <= 1'b1;
          else          updt_q <= shift_q[WIDTH-1:0];
`else
          updt_q <= shift_q[WIDTH-1:0];
`endif
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from registered state only.
  always_comb begin
    SCAN_OUT      = shift_q[0];
    SCAN_OUT_UPDT = updt_q;
    SHIFT_EN      = (state_q == StShift);
    BUSY          = (state_q == StCapture) || (state_q == StShift) || (state_q == StUpdate);
    DONE          = (state_q == StFin);
`ifdef SCAN_PARITY_EN
    PARITY_ERR    = perr_q;
`else
    PARITY_ERR    = 1'b0;
`endif
  end

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Bench for scan_chain_ctrl (WIDTH=8); transaction-level reference model.
module tb_scan_chain_ctrl;
  localparam int W = 8;
`ifdef SCAN_PARITY_EN
  localparam int L   = W + 1;
  localparam bit PAR = 1'b1;
`else
  localparam int L   = W;
  localparam bit PAR = 1'b0;
`endif

  logic         CLK, RESET, START, SCAN_IN;
  logic [1:0]   MODE;
  logic [W-1:0] SCAN_CAPTURE_IN, SCAN_OUT_UPDT;
  logic         SCAN_OUT, SHIFT_EN, BUSY, DONE, PARITY_ERR;

  int checks = 0;
  int errors = 0;

  // Reference model state: chain contents, update register, error flag.
  logic [L-1:0] chain_m;
  logic [W-1:0] updt_m;
  logic         perr_m;

  scan_chain_ctrl #(.WIDTH(W)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .MODE(MODE), .SCAN_IN(SCAN_IN),
    .SCAN_CAPTURE_IN(SCAN_CAPTURE_IN), .SCAN_OUT(SCAN_OUT), .SCAN_OUT_UPDT(SCAN_OUT_UPDT),
    .SHIFT_EN(SHIFT_EN), .BUSY(BUSY), .DONE(DONE), .PARITY_ERR(PARITY_ERR)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Transaction model: what the chain shows while shifting, and what it leaves behind.
  task automatic model_txn(input logic [1:0] mode, input logic [W-1:0] cap,
                           input logic [L-1:0] stream, output logic [L-1:0] exp_obs,
                           output int exp_done);
    logic [L-1:0] cap_full;
    cap_full = L'(cap);
    if (PAR) cap_full[L-1] = ^cap;
    exp_obs = mode[0] ? cap_full : chain_m;
    chain_m = stream;
    perr_m  = 1'b0;
    if (mode[1]) begin
      if (PAR && (^stream)) perr_m = 1'b1;
      else                  updt_m = stream[W-1:0];
    end
    exp_done = L + 1 + int'(mode[0]) + int'(mode[1]);
  endtask

  // Drives one request from a negedge and records what the DUT does; cycle c = c-th negedge.
  task automatic do_txn(input logic [1:0] mode, input logic [W-1:0] cap,
                        input logic [L-1:0] stream, input bit noise,
                        output logic [L-1:0] obs, output int done_cycle, output int done_count,
                        output int shift_cycles, output logic perr_c1, output logic busy_c1);
    bit seen;
    int post;
    obs = '0; done_cycle = -1; done_count = 0; shift_cycles = 0;
    perr_c1 = 1'b1; busy_c1 = 1'b0; seen = 1'b0; post = 0;
    START = 1'b1; MODE = mode; SCAN_CAPTURE_IN = cap;
    for (int cyc = 1; cyc <= 40 && post < 3; cyc++) begin
      @(negedge CLK);
      if (cyc == 1) begin
        perr_c1 = PARITY_ERR;
        busy_c1 = BUSY;
      end
      if (SHIFT_EN) begin
        if (shift_cycles < L) begin
          obs[shift_cycles] = SCAN_OUT;
          SCAN_IN = stream[shift_cycles];
        end
        shift_cycles++;
      end else begin
        SCAN_IN = 1'($urandom);
      end
      if (DONE) begin
        done_count++;
        if (done_cycle < 0) done_cycle = cyc;
      end
      // Keep requesting through FIN when noise is on; none of these may be accepted.
      START = noise && !seen;
      if (noise) MODE = 2'($urandom);
      if (seen) post++;
      if (DONE) seen = 1'b1;
    end
    START = 1'b0;
  endtask

  task automatic test_reset();
    logic [L-1:0] obs, exp_obs;
    int dc, dn, sc, exp_done;
    logic pc1, bc1;
    RESET = 1'b0; START = 1'b0; MODE = 2'b00; SCAN_IN = 1'b0; SCAN_CAPTURE_IN = '0;
    @(negedge CLK);
    @(negedge CLK);
    checks++;
    if ({SCAN_OUT, SHIFT_EN, BUSY, DONE, PARITY_ERR} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs got %b want 00000",
               {SCAN_OUT, SHIFT_EN, BUSY, DONE, PARITY_ERR});
    end
    checks++;
    if (SCAN_OUT_UPDT !== '0) begin
      errors++;
      $display("FAIL reset_updt got %h want 00", SCAN_OUT_UPDT);
    end
    chain_m = '0; updt_m = '0; perr_m = 1'b0;
    RESET = 1'b1;
    model_txn(2'b00, 8'h00, L'(8'h96), exp_obs, exp_done);
    do_txn(2'b00, 8'h00, L'(8'h96), 1'b0, obs, dc, dn, sc, pc1, bc1);
    checks++;
    if (bc1 !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_start_busy got %b want 1", bc1);
    end
    checks++;
    if (dc !== L + 1 || dn !== 1) begin
      errors++;
      $display("FAIL reset_first_done got cyc=%0d n=%0d want cyc=%0d n=1", dc, dn, L + 1);
    end
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL reset_chain_out got %h want 0", obs);
    end
  endtask

  task automatic test_full();
    logic [L-1:0] obs, exp_obs;
    int dc, dn, sc, exp_done;
    logic pc1, bc1;
    model_txn(2'b11, 8'hA5, L'(8'h4D), exp_obs, exp_done);
    do_txn(2'b11, 8'hA5, L'(8'h4D), 1'b0, obs, dc, dn, sc, pc1, bc1);
    checks++;
    if (obs[W-1:0] !== 8'hA5) begin
      errors++;
      $display("FAIL full_scan_out got %h want a5", obs[W-1:0]);
    end
    checks++;
    if (SCAN_OUT_UPDT !== 8'h4D) begin
      errors++;
      $display("FAIL full_updt got %h want 4d", SCAN_OUT_UPDT);
    end
    checks++;
    if (dc !== L + 3 || dn !== 1 || sc !== L) begin
      errors++;
      $display("FAIL full_timing got done=%0d n=%0d shifts=%0d want done=%0d n=1 shifts=%0d",
               dc, dn, sc, L + 3, L);
    end
    checks++;
    if (SCAN_OUT !== 1'b1) begin
      errors++;
      $display("FAIL full_idle_scan_out got %b want 1", SCAN_OUT);
    end
  endtask

  task automatic test_shift_only();
    logic [L-1:0] obs, exp_obs, stream;
    int dc, dn, sc, exp_done;
    logic pc1, bc1;
    stream = L'($urandom);
    model_txn(2'b00, 8'hFF, stream, exp_obs, exp_done);
    do_txn(2'b00, 8'hFF, stream, 1'b0, obs, dc, dn, sc, pc1, bc1);
    checks++;
    if (obs !== L'(8'h4D)) begin
      errors++;
      $display("FAIL shift_only_out got %h want %h", obs, L'(8'h4D));
    end
    checks++;
    if (SCAN_OUT_UPDT !== 8'h4D) begin
      errors++;
      $display("FAIL shift_only_updt got %h want 4d", SCAN_OUT_UPDT);
    end
    checks++;
    if (dc !== L + 1 || sc !== L || dn !== 1) begin
      errors++;
      $display("FAIL shift_only_timing got done=%0d shifts=%0d n=%0d want done=%0d shifts=%0d n=1",
               dc, sc, dn, L + 1, L);
    end
  endtask

  task automatic test_back_to_back();
    logic [L-1:0] obs, exp_obs, stream;
    logic [W-1:0] cap;
    logic [1:0] mode;
    int dc, dn, sc, exp_done;
    logic pc1, bc1;
    for (int i = 0; i < 4; i++) begin
      mode = 2'(i); cap = W'($urandom); stream = L'($urandom);
      if (PAR) stream[L-1] = ^stream[W-1:0];
      model_txn(mode, cap, stream, exp_obs, exp_done);
      do_txn(mode, cap, stream, 1'b1, obs, dc, dn, sc, pc1, bc1);
      checks++;
      if (dn !== 1 || dc !== exp_done) begin
        errors++;
        $display("FAIL b2b_done[%0d] got n=%0d cyc=%0d want n=1 cyc=%0d", i, dn, dc, exp_done);
      end
      checks++;
      if (obs !== exp_obs || SCAN_OUT_UPDT !== updt_m) begin
        errors++;
        $display("FAIL b2b_data[%0d] got out=%h updt=%h want out=%h updt=%h",
                 i, obs, SCAN_OUT_UPDT, exp_obs, updt_m);
      end
    end
  endtask

  task automatic test_abort();
    logic [L-1:0] obs, exp_obs, stream;
    int dc, dn, sc, exp_done, shifts, dones;
    logic pc1, bc1;
    bit hit;
    START = 1'b1; MODE = 2'b11; SCAN_CAPTURE_IN = 8'h3C;
    shifts = 0; hit = 1'b0;
    for (int cyc = 0; cyc < 20 && !hit; cyc++) begin
      @(negedge CLK);
      START = 1'b0;
      SCAN_IN = 1'($urandom);
      if (SHIFT_EN) shifts++;
      if (shifts == 4) begin
        RESET = 1'b0;
        hit = 1'b1;
      end
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL abort_reach_shift got shifts=%0d want 4", shifts);
    end
    @(negedge CLK);
    RESET = 1'b1;
    checks++;
    if ({BUSY, SHIFT_EN, DONE, SCAN_OUT} !== 4'b0 || SCAN_OUT_UPDT !== '0) begin
      errors++;
      $display("FAIL abort_state got flags=%b updt=%h want flags=0000 updt=00",
               {BUSY, SHIFT_EN, DONE, SCAN_OUT}, SCAN_OUT_UPDT);
    end
    chain_m = '0; updt_m = '0; perr_m = 1'b0;
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      if (DONE || BUSY) dones++;
    end
    checks++;
    if (dones !== 0) begin
      errors++;
      $display("FAIL abort_no_done got %0d active cycles want 0", dones);
    end
    stream = L'(8'hE1);
    model_txn(2'b11, 8'h5A, stream, exp_obs, exp_done);
    do_txn(2'b11, 8'h5A, stream, 1'b0, obs, dc, dn, sc, pc1, bc1);
    checks++;
    if (obs !== exp_obs || SCAN_OUT_UPDT !== updt_m || dc !== exp_done || dn !== 1) begin
      errors++;
      $display("FAIL abort_recover got out=%h updt=%h done=%0d n=%0d want out=%h updt=%h done=%0d n=1",
               obs, SCAN_OUT_UPDT, dc, dn, exp_obs, updt_m, exp_done);
    end
  endtask

`ifdef SCAN_PARITY_EN
  task automatic test_parity();
    logic [L-1:0] obs, exp_obs;
    logic [L-1:0] streams [3];
    logic [W-1:0] want_updt [3];
    logic want_err [3];
    int dc, dn, sc, exp_done;
    logic pc1, bc1;
    streams[0] = {1'b0, 8'h3C}; want_updt[0] = 8'h3C; want_err[0] = 1'b0;
    streams[1] = {1'b1, 8'h4D}; want_updt[1] = 8'h3C; want_err[1] = 1'b1;
    streams[2] = {1'b0, 8'h4D}; want_updt[2] = 8'h4D; want_err[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      model_txn(2'b10, 8'h00, streams[i], exp_obs, exp_done);
      do_txn(2'b10, 8'h00, streams[i], 1'b0, obs, dc, dn, sc, pc1, bc1);
      checks++;
      if (SCAN_OUT_UPDT !== want_updt[i] || PARITY_ERR !== want_err[i]) begin
        errors++;
        $display("FAIL parity[%0d] got updt=%h err=%b want updt=%h err=%b",
                 i, SCAN_OUT_UPDT, PARITY_ERR, want_updt[i], want_err[i]);
      end
      checks++;
      if (pc1 !== 1'b0) begin
        errors++;
        $display("FAIL parity_clear_on_start[%0d] got %b want 0", i, pc1);
      end
    end
  endtask
`endif

  task automatic test_random();
    logic [L-1:0] obs, exp_obs, stream;
    logic [W-1:0] cap;
    logic [1:0] mode;
    bit noise;
    int dc, dn, sc, exp_done;
    logic pc1, bc1;
    for (int i = 0; i < 20; i++) begin
      mode = 2'($urandom); cap = W'($urandom); stream = L'($urandom); noise = 1'($urandom);
      model_txn(mode, cap, stream, exp_obs, exp_done);
      do_txn(mode, cap, stream, noise, obs, dc, dn, sc, pc1, bc1);
      checks++;
      if (obs !== exp_obs || SCAN_OUT !== chain_m[0]) begin
        errors++;
        $display("FAIL rand_serial[%0d] got out=%h so=%b want out=%h so=%b",
                 i, obs, SCAN_OUT, exp_obs, chain_m[0]);
      end
      checks++;
      if (dc !== exp_done || dn !== 1 || sc !== L || bc1 !== 1'b1 || pc1 !== 1'b0) begin
        errors++;
        $display("FAIL rand_timing[%0d] got done=%0d n=%0d sh=%0d b=%b p=%b want done=%0d n=1 sh=%0d b=1 p=0",
                 i, dc, dn, sc, bc1, pc1, exp_done, L);
      end
      checks++;
      if (SCAN_OUT_UPDT !== updt_m || PARITY_ERR !== perr_m) begin
        errors++;
        $display("FAIL rand_update[%0d] got updt=%h err=%b want updt=%h err=%b",
                 i, SCAN_OUT_UPDT, PARITY_ERR, updt_m, perr_m);
      end
    end
  endtask

  initial begin
    RESET = 1'b0; START = 1'b0; MODE = 2'b00; SCAN_IN = 1'b0; SCAN_CAPTURE_IN = '0;
    test_reset();
    test_full();
    test_shift_only();
    test_back_to_back();
    test_abort();
`ifdef SCAN_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
